// File: rtl/mem_sweep_arbiter_pkg.sv
// Shared types and default constants for the memory sweep / arbitration block.
package mem_sweep_pkg;

  // Top-level operating mode: initialise every word, or share the port among clients.
  typedef enum logic {
    SWEEP = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam int             DEF_DEPTH    = 4096;
  localparam int             DEF_DW       = 8;
  localparam logic [7:0]     DEF_INIT_VAL = 8'hFF;
  // Bit of each stored word that marks it as defined (1 = defined).
  localparam int             DEFINED_BIT  = 0;

endpackage

// File: rtl/mem_sweep_arbiter_if.sv
// Client and memory-port bundle of mem_sweep_arbiter. The arbiter is the slave;
// the clients plus the external memory array sit on the master side.
interface mem_sweep_arbiter_if
  import mem_sweep_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = $clog2(DEF_DEPTH),
  parameter int DW   = DEF_DW
);
  logic [NREQ-1:0]    IN_req_valid;
  logic [NREQ-1:0]    IN_req_we;
  logic [NREQ*AW-1:0] IN_req_addr;
  logic [NREQ*DW-1:0] IN_req_wdata;
  logic [NREQ-1:0]    OUT_req_ready;
  logic [NREQ-1:0]    OUT_rsp_valid;
  logic [DW-1:0]      OUT_rsp_rdata;
  logic               OUT_mem_en;
  logic               OUT_mem_we;
  logic [AW-1:0]      OUT_mem_addr;
  logic [DW-1:0]      OUT_mem_wdata;
  logic [DW-1:0]      IN_mem_rdata;

  modport slave (
    input  IN_req_valid, IN_req_we, IN_req_addr, IN_req_wdata, IN_mem_rdata,
    output OUT_req_ready, OUT_rsp_valid, OUT_rsp_rdata,
           OUT_mem_en, OUT_mem_we, OUT_mem_addr, OUT_mem_wdata
  );

  modport master (
    output IN_req_valid, IN_req_we, IN_req_addr, IN_req_wdata, IN_mem_rdata,
    input  OUT_req_ready, OUT_rsp_valid, OUT_rsp_rdata,
           OUT_mem_en, OUT_mem_we, OUT_mem_addr, OUT_mem_wdata
  );
endinterface

// File: rtl/mem_sweep_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr, cyclically.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan N positions starting at ptr; the first valid one wins.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!any && valid[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mem_sweep_arbiter.sv
// Initialises an external single-port memory by sweeping INIT_VAL into every word,
// then shares the port among NREQ clients with a round-robin grant.
module mem_sweep_arbiter
  import mem_sweep_pkg::*;
#(
  parameter int             DEPTH    = DEF_DEPTH,
  parameter int             AW       = $clog2(DEPTH),
  parameter int             DW       = DEF_DW,
  parameter logic [DW-1:0]  INIT_VAL = DEF_INIT_VAL,
  parameter int             NREQ     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IN_init,
  output logic              OUT_busy,
  mem_sweep_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  state_t        state, state_nxt;
  logic [AW-1:0] sweep_addr, sweep_nxt;
  logic [IW-1:0] rr_ptr;
  logic          rsp_pend;
  logic [IW-1:0] rsp_idx;

  logic [NREQ-1:0] serve_valid;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            gany;

  // Clients are only considered while serving; the sweep owns the port otherwise.
  assign serve_valid = (state == SERVE) ? bus.IN_req_valid : '0;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr_arbiter (
    .valid (serve_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  assign bus.OUT_req_ready = grant;
  assign bus.OUT_rsp_rdata = bus.IN_mem_rdata;
  assign OUT_busy          = (state == SWEEP);

  // Next mode and sweep address: init restarts the sweep, last word hands over to SERVE.
  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_addr;
    unique case (state)
      SWEEP: begin
        if (IN_init) begin
          sweep_nxt = '0;
        end else if (sweep_addr == AW'(DEPTH - 1)) begin
          sweep_nxt = '0;
          state_nxt = SERVE;
        end else begin
          sweep_nxt = sweep_addr + AW'(1);
        end
      end
      SERVE: begin
        if (IN_init) begin
          sweep_nxt = '0;
          state_nxt = SWEEP;
        end
      end
      default: begin
        sweep_nxt = '0;
        state_nxt = SWEEP;
      end
    endcase
  end

  // Memory port mux: sweep write, granted client, or an all-zero idle port.
  always_comb begin
    bus.OUT_mem_en    = 1'b0;
    bus.OUT_mem_we    = 1'b0;
    bus.OUT_mem_addr  = '0;
    bus.OUT_mem_wdata = '0;
    if (state == SWEEP) begin
      bus.OUT_mem_en    = 1'b1;
      bus.OUT_mem_we    = 1'b1;
      bus.OUT_mem_addr  = sweep_addr;
      bus.OUT_mem_wdata = INIT_VAL;
    end else if (gany) begin
      bus.OUT_mem_en    = 1'b1;
      bus.OUT_mem_we    = bus.IN_req_we[gidx];
      bus.OUT_mem_addr  = bus.IN_req_addr[int'(gidx)*AW +: AW];
      bus.OUT_mem_wdata = bus.IN_req_wdata[int'(gidx)*DW +: DW];
    end
  end

  // Response strobe decoded from the read tag captured at grant time.
  always_comb begin
    bus.OUT_rsp_valid = '0;
    if (rsp_pend) bus.OUT_rsp_valid[rsp_idx] = 1'b1;
  end

  // Mode, sweep counter, round-robin pointer and one-deep read tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SWEEP;
      sweep_addr <= '0;
      rr_ptr     <= '0;
      rsp_pend   <= 1'b0;
      rsp_idx    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state      <= state_nxt;
      sweep_addr <= sweep_nxt;
      if (gany) rr_ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + IW'(1);
      rsp_pend   <= gany & ~bus.IN_req_we[gidx];
      rsp_idx    <= gidx;
    end
  end

endmodule

// File: tb/tb_mem_sweep_arbiter.sv
// Self-checking bench for mem_sweep_arbiter: external memory model, a reference
// model of grants/contents/responses, directed scenarios plus random traffic.
module tb_mem_sweep_arbiter;
  import mem_sweep_pkg::*;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int NREQ  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic init  = 1'b0;
  logic busy;

  mem_sweep_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem_sweep_arbiter #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .INIT_VAL(8'hFF), .NREQ(NREQ)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .IN_init  (init),
    .OUT_busy (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // External memory array: 1-cycle read latency.
  logic [DW-1:0] env_mem [DEPTH];
  always @(posedge clk) begin
    if (bus.OUT_mem_en) begin
      if (bus.OUT_mem_we) env_mem[bus.OUT_mem_addr] <= bus.OUT_mem_wdata;
      else                bus.IN_mem_rdata <= env_mem[bus.OUT_mem_addr];
    end
  end

  // Reference model state.
  int            n_checks;
  int            n_fails;
  int            ref_ptr;
  bit            ref_busy;
  bit            exp_pend;
  int            exp_idx;
  logic [DW-1:0] exp_data;
  logic [DW-1:0] ref_mem [DEPTH];

  // Count one comparison; report and count it when it does not hold.
  task automatic check(input bit ok, input string msg);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL %s", msg);
    end
  endtask

  // One SERVE-mode cycle: drive, check against the model, advance the model.
  task automatic serve_cycle(input logic [1:0] valid, input logic [1:0] we,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input logic do_init, input string tag);
    int            g;
    logic [1:0]    exp_ready;
    logic [1:0]    exp_rv;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    bus.IN_req_valid = valid;
    bus.IN_req_we    = we;
    bus.IN_req_addr  = {a1, a0};
    bus.IN_req_wdata = {d1, d0};
    init             = do_init;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (ref_ptr + k) % NREQ;
      if (g < 0 && valid[c]) g = c;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check(bus.OUT_req_ready === exp_ready && busy === 1'b0,
          $sformatf("%s ready: got ready=%b busy=%b, want ready=%b busy=0",
                    tag, bus.OUT_req_ready, busy, exp_ready));
    exp_rv = '0;
    if (exp_pend) exp_rv[exp_idx] = 1'b1;
    check(bus.OUT_rsp_valid === exp_rv && !(exp_pend && bus.OUT_rsp_rdata !== exp_data),
          $sformatf("%s rsp: got valid=%b rdata=%h, want valid=%b rdata=%h",
                    tag, bus.OUT_rsp_valid, bus.OUT_rsp_rdata, exp_rv, exp_data));
    e_en   = (g >= 0);
    e_we   = (g >= 0) ? we[g] : 1'b0;
    e_addr = (g == 0) ? a0 : (g == 1) ? a1 : '0;
    e_wd   = (g >= 0 && we[g]) ? ((g == 0) ? d0 : d1) : '0;
    check(!(bus.OUT_mem_en !== e_en || bus.OUT_mem_we !== e_we || bus.OUT_mem_addr !== e_addr ||
            (e_we && bus.OUT_mem_wdata !== e_wd) || (!e_en && bus.OUT_mem_wdata !== '0)),
          $sformatf("%s mem_port: got en=%b we=%b addr=%h wdata=%h, want en=%b we=%b addr=%h wdata=%h",
                    tag, bus.OUT_mem_en, bus.OUT_mem_we, bus.OUT_mem_addr, bus.OUT_mem_wdata,
                    e_en, e_we, e_addr, e_wd));
    if (g >= 0) begin
      ref_ptr = (g + 1) % NREQ;
      if (we[g]) ref_mem[e_addr] = e_wd;
      exp_pend = !we[g];
      exp_idx  = g;
      exp_data = ref_mem[e_addr];
    end else begin
      exp_pend = 1'b0;
    end
    if (do_init) ref_busy = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // n sweep cycles expecting writes of FF to 0..n-1; optional init on the last one.
  task automatic sweep_run(input int n, input bit init_last, input string tag);
    int         bad;
    int         first_bad;
    logic [1:0] exp_rv;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < n; i++) begin
      bus.IN_req_valid = 2'b11;
      bus.IN_req_we    = 2'b00;
      init             = init_last && (i == n - 1);
      #1;
      if (i == 0) begin
        exp_rv = '0;
        if (exp_pend) exp_rv[exp_idx] = 1'b1;
        check(bus.OUT_rsp_valid === exp_rv && !(exp_pend && bus.OUT_rsp_rdata !== exp_data),
              $sformatf("%s first_rsp: got valid=%b rdata=%h, want valid=%b rdata=%h",
                        tag, bus.OUT_rsp_valid, bus.OUT_rsp_rdata, exp_rv, exp_data));
        exp_pend = 1'b0;
      end else if (bus.OUT_rsp_valid !== 2'b00) begin
        bad++;
      end
      if (bus.OUT_mem_en !== 1'b1 || bus.OUT_mem_we !== 1'b1 || bus.OUT_mem_addr !== AW'(i) ||
          bus.OUT_mem_wdata !== 8'hFF || bus.OUT_req_ready !== 2'b00 || busy !== 1'b1) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
      ref_mem[i] = 8'hFF;
      @(negedge clk);
    end
    init = 1'b0;
    check(bad == 0,
          $sformatf("%s sequence: got %0d bad cycles (first at cycle %0d), want 0 of %0d",
                    tag, bad, first_bad, n));
    if (n == DEPTH && !init_last) ref_busy = 1'b0;
  endtask

  // Pulse reset at a negedge, check reset outputs, release before the next edge.
  task automatic do_reset(input string tag);
    bus.IN_req_valid = 2'b11;
    bus.IN_req_we    = 2'b00;
    rst_n = 1'b0;
    #1;
    check(busy === 1'b1 && bus.OUT_rsp_valid === 2'b00 && bus.OUT_req_ready === 2'b00 &&
          bus.OUT_mem_addr === '0,
          $sformatf("%s: got busy=%b rsp_valid=%b ready=%b addr=%h, want busy=1 rsp_valid=00 ready=00 addr=000",
                    tag, busy, bus.OUT_rsp_valid, bus.OUT_req_ready, bus.OUT_mem_addr));
    ref_ptr  = 0;
    exp_pend = 1'b0;
    ref_busy = 1'b1;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    do_reset("reset_state");
  endtask

  task automatic test_sweep_after_reset();
    sweep_run(DEPTH, 1'b0, "sweep_after_reset");
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 8; i++)
      serve_cycle(2'b11, 2'b00, AW'($urandom), AW'($urandom), 8'h00, 8'h00, 1'b0, "round_robin");
    serve_cycle(2'b00, 2'b00, '0, '0, '0, '0, 1'b0, "rr_idle");
  endtask

  task automatic test_write_then_read();
    serve_cycle(2'b01, 2'b01, 12'h123, 12'h000, 8'h5A, 8'h00, 1'b0, "wr_req0");
    serve_cycle(2'b10, 2'b00, 12'h000, 12'h123, 8'h00, 8'h00, 1'b0, "rd_req1");
    serve_cycle(2'b00, 2'b00, '0, '0, '0, '0, 1'b0, "rd_req1_rsp");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      serve_cycle(2'($urandom), 2'($urandom),
                  AW'(12'h120 + $urandom_range(0, 7)), AW'(12'h120 + $urandom_range(0, 7)),
                  8'($urandom), 8'($urandom), 1'b0, "random");
    serve_cycle(2'b00, 2'b00, '0, '0, '0, '0, 1'b0, "random_drain");
  endtask

  task automatic test_init_in_serve();
    serve_cycle(2'b01, 2'b00, 12'h010, 12'h000, 8'h00, 8'h00, 1'b1, "init_with_read");
    sweep_run(DEPTH, 1'b0, "init_in_serve_sweep");
    serve_cycle(2'b00, 2'b00, '0, '0, '0, '0, 1'b0, "after_init_sweep");
  endtask

  task automatic test_reset_drop();
    bus.IN_req_valid = 2'b01;
    bus.IN_req_we    = 2'b00;
    bus.IN_req_addr  = {12'h000, 12'h123};
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check(bus.OUT_rsp_valid === 2'b00 && busy === 1'b1,
          $sformatf("reset_drop: got rsp_valid=%b busy=%b, want rsp_valid=00 busy=1",
                    bus.OUT_rsp_valid, busy));
    ref_ptr  = 0;
    exp_pend = 1'b0;
    ref_busy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    sweep_run(DEPTH, 1'b0, "reset_drop_sweep");
    serve_cycle(2'b00, 2'b00, '0, '0, '0, '0, 1'b0, "after_reset_drop");
  endtask

  task automatic test_reset_mid_sweep();
    serve_cycle(2'b00, 2'b00, '0, '0, '0, '0, 1'b1, "init_for_reset");
    sweep_run(12'h800, 1'b0, "sweep_to_800");
    do_reset("reset_at_800");
    sweep_run(DEPTH, 1'b0, "sweep_after_reset_800");
    serve_cycle(2'b11, 2'b00, 12'h123, 12'h010, '0, '0, 1'b0, "serve_after_reset_800");
    serve_cycle(2'b00, 2'b00, '0, '0, '0, '0, 1'b0, "drain_after_reset_800");
  endtask

  task automatic test_init_mid_sweep();
    serve_cycle(2'b00, 2'b00, '0, '0, '0, '0, 1'b1, "init_for_restart");
    sweep_run(12'h401, 1'b1, "sweep_to_400_init");
    sweep_run(DEPTH, 1'b0, "sweep_after_restart");
    serve_cycle(2'b10, 2'b00, '0, 12'h123, '0, '0, 1'b0, "serve_after_restart");
    serve_cycle(2'b00, 2'b00, '0, '0, '0, '0, 1'b0, "drain_after_restart");
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    ref_ptr  = 0;
    ref_busy = 1'b1;
    exp_pend = 1'b0;
    exp_idx  = 0;
    exp_data = '0;
    bus.IN_req_valid = '0;
    bus.IN_req_we    = '0;
    bus.IN_req_addr  = '0;
    bus.IN_req_wdata = '0;
    test_reset();
    test_sweep_after_reset();
    test_round_robin();
    test_write_then_read();
    test_random();
    test_init_in_serve();
    test_reset_drop();
    test_reset_mid_sweep();
    test_init_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
